mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one 2:1 4-bit multiplexer datapath between two requesters (A, B).
- Drives the mux select, captures the selected word into a single-entry output register, and presents it downstream with a valid/ready handshake.
- Sits between producer stages and a shared 4-bit bus in the processor datapath.

---
 rtl/mux4_rr_arbiter_if.sv | 20 ++
 rtl/mux4_rr_arbiter.sv | 82 ++++++++
 tb/tb_mux4_rr_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester, output and optional stats signals of the shared 4-bit mux arbiter
// master: producers and downstream side; slave: the arbiter
// Optional counters are enabled with MUX4_RR_ARBITER_STATS_EN
interface mux4_rr_arbiter_if;
  logic       req_a, ack_a, req_b, ack_b, sel, out_valid, out_ready, out_src;
  logic [3:0] data_a, data_b, out_data;
`ifdef MUX4_RR_ARBITER_STATS_EN
  logic       stats_clr;
  logic [7:0] cnt_a, cnt_b;
  modport master (output req_a, data_a, req_b, data_b, out_ready, stats_clr,
                  input ack_a, ack_b, sel, out_valid, out_data, out_src, cnt_a, cnt_b);
  modport slave  (input req_a, data_a, req_b, data_b, out_ready, stats_clr,
                  output ack_a, ack_b, sel, out_valid, out_data, out_src, cnt_a, cnt_b);
`else
  modport master (output req_a, data_a, req_b, data_b, out_ready,
                  input ack_a, ack_b, sel, out_valid, out_data, out_src);
  modport slave  (input req_a, data_a, req_b, data_b, out_ready,
                  output ack_a, ack_b, sel, out_valid, out_data, out_src);
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin A/B arbiter driving a 2:1 4-bit mux into a valid/ready output register
// Ports: clk, reset (sync, active-high), bus (slave modport: req/data/ack per requester,
//   sel, out_valid/out_ready/out_data/out_src, plus stats_clr/cnt_a/cnt_b with MUX4_RR_ARBITER_STATS_EN)
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             reset,
  mux4_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t     r_state;
  logic [3:0] r_burst, r_data;
  logic       r_last, r_valid, r_src;
  logic       w_sel, w_can_load, w_ack_a, w_ack_b, w_ack, w_req_cur, w_req_oth, w_oth, w_sw, w_pick_a;
  logic [3:0] w_inc;
  assign w_sel      = r_state == GRANT_B;
  assign w_can_load = !r_valid || bus.out_ready;
  // acks are suppressed during reset so a word is never accepted and then dropped
  assign w_ack_a    = r_state == GRANT_A && bus.req_a && w_can_load && !reset;
  assign w_ack_b    = r_state == GRANT_B && bus.req_b && w_can_load && !reset;
  assign w_ack      = w_ack_a || w_ack_b;
  assign w_req_cur  = w_sel ? bus.req_b : bus.req_a;
  assign w_req_oth  = w_sel ? bus.req_a : bus.req_b;
  assign w_oth      = !w_sel;
  assign w_inc      = (w_ack && r_burst != MB) ? r_burst + 4'd1 : r_burst;
  // burst preemption only on an actual transfer, so a stall never moves the grant
  assign w_sw       = w_req_oth && (!w_req_cur || (w_ack && w_inc == MB));
  // last_grant: 0 = A, 1 = B; on a tie the requester that was not granted last wins
  assign w_pick_a   = bus.req_a && (!bus.req_b || r_last);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_burst <= 4'd0;
      r_last  <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= 4'h0;
      r_src   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_a || bus.req_b) begin
          r_state <= w_pick_a ? GRANT_A : GRANT_B;
          r_last  <= !w_pick_a;
          r_burst <= 4'd0;
        end
        GRANT_A, GRANT_B: if (w_sw) begin
          r_state <= w_oth ? GRANT_B : GRANT_A;
          r_last  <= w_oth;
          r_burst <= 4'd0;
        end else if (!w_req_cur) r_state <= IDLE;
        else r_burst <= w_inc;
        default: r_state <= IDLE;
      endcase
      if (w_ack) begin
        r_data  <= w_sel ? bus.data_b : bus.data_a;
        r_src   <= w_sel;
        r_valid <= 1'b1;
      end else if (bus.out_ready) r_valid <= 1'b0;
    end
  end
  assign bus.ack_a     = w_ack_a;
  assign bus.ack_b     = w_ack_b;
  assign bus.sel       = w_sel;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
`ifdef MUX4_RR_ARBITER_STATS_EN
  logic [7:0] r_cnt_a, r_cnt_b;
  always_ff @(posedge clk) begin
    if (reset || bus.stats_clr) begin
      r_cnt_a <= 8'd0;
      r_cnt_b <= 8'd0;
    end else begin
      r_cnt_a <= r_cnt_a + {7'd0, w_ack_a};
      r_cnt_b <= r_cnt_b + {7'd0, w_ack_b};
    end
  end
  assign bus.cnt_a = r_cnt_a;
  assign bus.cnt_b = r_cnt_b;
`endif
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scoreboard bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [4:0] q[$];
  mux4_rr_arbiter_if bus();
  mux4_rr_arbiter #(.MAX_BURST(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // one cycle: check acks/sel before the edge, push expected words, advance producer data
  task automatic tick(input logic ea, input logic eb, input logic es, input string nm);
    @(negedge clk);
    chk({nm, "_ack_a"}, {7'd0, bus.ack_a}, {7'd0, ea});
    chk({nm, "_ack_b"}, {7'd0, bus.ack_b}, {7'd0, eb});
    chk({nm, "_sel"}, {7'd0, bus.sel}, {7'd0, es});
    if (ea) q.push_back({1'b0, bus.data_a});
    if (eb) q.push_back({1'b1, bus.data_b});
    @(posedge clk);
    #1;
    if (ea) bus.data_a = bus.data_a + 4'd1;
    if (eb) bus.data_b = bus.data_b + 4'd1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  // monitor: every downstream transfer must match the oldest expected word
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%0h expected=none", {bus.out_src, bus.out_data});
        end else begin
          e = q.pop_front();
          chk("sb_word", {3'd0, bus.out_src, bus.out_data}, {3'd0, e});
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.data_a = 4'h0;
    bus.data_b = 4'h0;
    bus.out_ready = 1'b1;
`ifdef MUX4_RR_ARBITER_STATS_EN
    bus.stats_clr = 1'b0;
`endif
    do_reset();
    chk("rst_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst_data", {4'd0, bus.out_data}, 8'd0);
    chk("rst_src", {7'd0, bus.out_src}, 8'd0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, "idle");
    chk("idle_valid", {7'd0, bus.out_valid}, 8'd0);
    bus.req_a = 1'b1;
    bus.data_a = 4'hA;
    tick(0, 0, 0, "single_c0");
    tick(1, 0, 0, "single_c1");
    bus.req_a = 1'b0;
    chk("single_valid", {7'd0, bus.out_valid}, 8'd1);
    chk("single_data", {4'd0, bus.out_data}, 8'hA);
    chk("single_src", {7'd0, bus.out_src}, 8'd0);
    tick(0, 0, 0, "single_c2");
    tick(0, 0, 0, "single_c3");
    do_reset();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    bus.data_a = 4'h0;
    bus.data_b = 4'h8;
    tick(0, 0, 0, "rr_idle");
    for (int i = 0; i < 4; i++) tick(1, 0, 0, "rr_a1");
    for (int i = 0; i < 4; i++) tick(0, 1, 1, "rr_b");
    for (int i = 0; i < 4; i++) tick(1, 0, 0, "rr_a2");
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    tick(0, 0, 1, "rr_drop");
    tick(0, 0, 0, "rr_done");
    do_reset();
    bus.req_a = 1'b1;
    bus.data_a = 4'h3;
    tick(0, 0, 0, "stall_idle");
    tick(1, 0, 0, "stall_first");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, "stall_hold");
      chk("stall_data", {4'd0, bus.out_data}, 8'h3);
      chk("stall_valid", {7'd0, bus.out_valid}, 8'd1);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, "stall_resume");
    bus.req_a = 1'b0;
    tick(0, 0, 0, "stall_drop");
    tick(0, 0, 0, "stall_done");
    do_reset();
    bus.req_b = 1'b1;
    bus.data_b = 4'h5;
    tick(0, 0, 0, "rstack_idle");
    reset = 1'b1;
    tick(0, 0, 1, "rstack_cut");
    chk("rstack_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rstack_sel", {7'd0, bus.sel}, 8'd0);
    reset = 1'b0;
    bus.req_a = 1'b1;
    bus.data_a = 4'h7;
    tick(0, 0, 0, "rstack_tie");
    tick(1, 0, 0, "rstack_a");
    bus.req_a = 1'b0;
    tick(0, 0, 0, "rstack_handover");
    tick(0, 1, 1, "rstack_b");
    bus.req_b = 1'b0;
    tick(0, 0, 1, "rstack_drop");
    tick(0, 0, 0, "rstack_done");
`ifdef MUX4_RR_ARBITER_STATS_EN
    do_reset();
    chk("stats_rst_a", bus.cnt_a, 8'd0);
    chk("stats_rst_b", bus.cnt_b, 8'd0);
    bus.req_a = 1'b1;
    tick(0, 0, 0, "stats_idle");
    for (int i = 0; i < 300; i++) tick(1, 0, 0, "stats_run");
    bus.req_a = 1'b0;
    chk("stats_cnt_a", bus.cnt_a, 8'd44);
    chk("stats_cnt_b", bus.cnt_b, 8'd0);
    tick(0, 0, 0, "stats_drop");
    bus.req_a = 1'b1;
    tick(0, 0, 0, "stats_idle2");
    bus.stats_clr = 1'b1;
    tick(1, 0, 0, "stats_clr_ack");
    bus.stats_clr = 1'b0;
    bus.req_a = 1'b0;
    chk("stats_clr_a", bus.cnt_a, 8'd0);
    chk("stats_clr_b", bus.cnt_b, 8'd0);
    tick(0, 0, 0, "stats_drop2");
    tick(0, 0, 0, "stats_done");
`endif
    repeat (2) @(posedge clk);
    chk("sb_drained", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
